ifetch: RTL and testbench

//  Instruction fetch stage, directly downstream of the pc block.
//  - Takes the current PC (pc.cur) and issues one instruction-memory read per PC value.
//  - Buffers returned words in a small FIFO.
//  - Presents {inst, pc} pairs to decode over a valid/ready handshake.
//  - Drives pc_hold so the PC advances only when a fetch is accepted.
//  - Discards in-flight and buffered words on a redirect (flush).

---
 rtl/ifetch.sv | 130 +++++++++++++
 tb/tb_ifetch.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch.sv
// Instruction fetch stage: one imem read per PC value, a small return FIFO,
// and a valid/ready handoff of {inst, pc} pairs to decode.
module ifetch #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_cur,
    output logic            pc_hold,
    input  logic            flush,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_inst,
    output logic [XLEN-1:0] id_pc
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [XLEN-1:0]  inst_mem_q [DEPTH];
    logic [XLEN-1:0]  pc_mem_q   [DEPTH];
    logic             imem_req_q, imem_req_d;
    logic [XLEN-1:0]  addr_q, addr_d;
    logic             id_valid_q, id_valid_d;

    logic inflight;
    logic space;
    logic space_after;
    logic fifo_wr;
    logic fifo_rd;

    // Next-state, FIFO bookkeeping and registered output values.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        addr_d     = addr_q;

        inflight = (state_q == WAIT) || (state_q == DROP);
        space    = (SUM_W'(count_q) + SUM_W'(inflight)) < SUM_W'(DEPTH);
        fifo_wr  = (state_q == WAIT) && imem_rvalid && !flush;
        fifo_rd  = id_valid_q && id_ready && !flush;

        if (flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(fifo_wr);
            rd_ptr_d = rd_ptr_q + PTR_W'(fifo_rd);
            case ({fifo_wr, fifo_rd})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
        space_after = SUM_W'(count_d) < SUM_W'(DEPTH);

        // A flush overrides the ordinary transition of each state.
        case (state_q)
            IDLE: if (space && !flush) state_d = REQ;
            REQ: begin
                if (imem_gnt)   state_d = flush ? DROP : WAIT;
                else if (flush) state_d = IDLE;
            end
            WAIT: begin
                if (imem_rvalid) state_d = (!flush && space_after) ? REQ : IDLE;
                else if (flush)  state_d = DROP;
            end
            DROP: if (imem_rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        imem_req_d = (state_d == REQ);
        if ((state_d == REQ) && (state_q != REQ)) begin
            addr_d = pc_cur & ~XLEN'(3);
        end
        id_valid_d = (count_d != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            imem_req_q <= 1'b0;
            addr_q     <= '0;
            id_valid_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                inst_mem_q[i] <= '0;
                pc_mem_q[i]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            imem_req_q <= imem_req_d;
            addr_q     <= addr_d;
            id_valid_q <= id_valid_d;
            if (fifo_wr) begin
                inst_mem_q[wr_ptr_q] <= imem_rdata;
                pc_mem_q[wr_ptr_q]   <= addr_q;
            end
        end
    end

    // Exactly one PC advance per granted request.
    assign pc_hold   = ~(imem_req_q & imem_gnt);
    assign imem_req  = imem_req_q;
    assign imem_addr = addr_q;
    assign id_valid  = id_valid_q;
    assign id_inst   = inst_mem_q[rd_ptr_q];
    assign id_pc     = pc_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: pc stage + latency-programmable imem model, a transaction-level
// scoreboard checked every cycle, and directed scenarios with literal expectations.
module tb_ifetch;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 2;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } word_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] due;
    } mreq_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_cur;
    logic        pc_hold;
    logic        flush = 1'b0;
    logic [31:0] jmp_target = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready = 1'b1;
    logic [31:0] id_inst;
    logic [31:0] id_pc;

    logic        gnt_en = 1'b1;
    logic        inj_rv = 1'b0;
    logic        mem_rv = 1'b0;
    logic [31:0] mem_rd = '0;
    int          lat = 1;
    int          cyc = 0;

    int total = 0;
    int bad   = 0;

    ifetch #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .pc_cur(pc_cur), .pc_hold(pc_hold), .flush(flush),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // pc stage: jump on flush, otherwise advance unless held.
    always @(posedge clk or negedge rst) begin
        if (!rst)          pc_cur <= '0;
        else if (flush)    pc_cur <= jmp_target;
        else if (!pc_hold) pc_cur <= pc_cur + 32'd4;
    end

    assign imem_gnt    = gnt_en & imem_req;
    assign imem_rvalid = mem_rv | inj_rv;
    assign imem_rdata  = inj_rv ? 32'hBAD0_BAD0 : mem_rd;

    mreq_t mq[$];

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) mq.delete();
            else if (imem_req && imem_gnt) mq.push_back('{addr: imem_addr, due: 32'(cyc + lat)});
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            if (mq.size() != 0 && mq[0].due <= 32'(cyc)) begin
                mem_rv = 1'b1;
                mem_rd = mem_word(mq[0].addr);
                void'(mq.pop_front());
            end else begin
                mem_rv = 1'b0;
            end
        end
    end

    // Scoreboard: granted addresses in flight, stale returns owed, and visible FIFO words.
    word_t       exp_q[$];
    logic [31:0] pend_q[$];
    int          stale = 0;
    logic        prev_req = 1'b0;
    logic        prev_gnt = 1'b0;
    logic        prev_flush = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] pop_addr;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("reset_req", 32'(imem_req), 32'd0);
                chk("reset_valid", 32'(id_valid), 32'd0);
                chk("reset_hold", 32'(pc_hold), 32'd1);
                chk("reset_addr", imem_addr, 32'd0);
                chk("reset_inst", id_inst, 32'd0);
                chk("reset_pc", id_pc, 32'd0);
                exp_q.delete();
                pend_q.delete();
                stale    = 0;
                prev_req = 1'b0;
            end else begin
                chk("id_valid", 32'(id_valid), 32'(exp_q.size() != 0));
                if (id_valid && exp_q.size() != 0) begin
                    chk("id_pc", id_pc, exp_q[0].pc);
                    chk("id_inst", id_inst, exp_q[0].inst);
                end
                chk("pc_hold", 32'(pc_hold), 32'(!(imem_req && imem_gnt)));
                if (imem_req) chk("addr_align", 32'(imem_addr[1:0]), 32'd0);
                if (imem_req && imem_gnt) chk("gnt_addr_is_pc", imem_addr, pc_cur & ~32'd3);
                if (prev_req && !prev_gnt && !prev_flush) begin
                    chk("req_held", 32'(imem_req), 32'd1);
                    chk("addr_held", imem_addr, prev_addr);
                end
                chk("occupancy", 32'(exp_q.size() + pend_q.size() <= DEPTH), 32'd1);

                if (id_valid && id_ready && !flush && exp_q.size() != 0) void'(exp_q.pop_front());
                if (imem_rvalid) begin
                    if (stale > 0) begin
                        stale--;
                    end else if (pend_q.size() != 0) begin
                        pop_addr = pend_q.pop_front();
                        if (!flush) exp_q.push_back('{inst: mem_word(pop_addr), pc: pop_addr});
                    end
                end
                if (imem_req && imem_gnt) begin
                    if (flush) stale++;
                    else       pend_q.push_back(imem_addr);
                end
                if (flush) begin
                    stale += pend_q.size();
                    pend_q.delete();
                    exp_q.delete();
                end
                prev_req   = imem_req;
                prev_gnt   = imem_gnt;
                prev_flush = flush;
                prev_addr  = imem_addr;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // which: 0 = grant, 1 = request, 2 = id_valid. Ends at the negedge where it is seen.
    task automatic wait_for(input int which, input int maxc, input string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < maxc && !hit; i++) begin
            @(negedge clk);
            case (which)
                0:       hit = imem_req && imem_gnt;
                1:       hit = imem_req;
                default: hit = id_valid;
            endcase
            if (!hit) begin
                @(posedge clk);
                #1;
            end
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL %s: event not seen within %0d cycles", name, maxc);
        end
    endtask

    int n_hs;
    int n_gnt;

    initial begin
        flush      = 1'b1;
        jmp_target = 32'h55;
        repeat (3) tick();
        neg();
        chk("t1_rst_req", 32'(imem_req), 32'd0);
        chk("t1_rst_valid", 32'(id_valid), 32'd0);
        chk("t1_rst_hold", 32'(pc_hold), 32'd1);
        tick();
        rst   = 1'b1;
        flush = 1'b0;
        neg();
        chk("t1_req_c0", 32'(imem_req), 32'd0);
        tick(); neg();
        chk("t1_req_c1", 32'(imem_req), 32'd1);
        chk("t1_addr_c1", imem_addr, 32'd0);
        chk("t1_hold_c1", 32'(pc_hold), 32'd0);
        tick(); neg();
        chk("t2_valid_c2", 32'(id_valid), 32'd0);
        tick(); neg();
        chk("t2_valid_c3", 32'(id_valid), 32'd1);
        chk("t2_first_pc", id_pc, 32'd0);
        chk("t2_first_inst", id_inst, 32'h0000_FFFF);

        n_hs  = 0;
        n_gnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (id_valid && id_ready) n_hs++;
            if (!pc_hold) n_gnt++;
            tick(); neg();
        end
        chk("t2_stream_words", 32'(n_hs), 32'd10);
        chk("t2_stream_gnts", 32'(n_gnt), 32'd10);

        // Backpressure with the decoder stalled.
        do_reset();
        id_ready = 1'b0;
        repeat (8) tick();
        neg();
        chk("t3_valid", 32'(id_valid), 32'd1);
        chk("t3_head_pc", id_pc, 32'd0);
        chk("t3_head_inst", id_inst, 32'h0000_FFFF);
        chk("t3_no_req", 32'(imem_req), 32'd0);
        chk("t3_hold", 32'(pc_hold), 32'd1);
        tick();
        id_ready = 1'b1;
        wait_for(0, 10, "t3_resume_gnt");
        chk("t3_resume_addr", imem_addr, 32'h8);

        // Flush while a request is outstanding and the FIFO holds a word.
        do_reset();
        id_ready = 1'b0;
        lat      = 3;
        wait_for(0, 10, "t4_gnt0");
        tick();
        wait_for(0, 10, "t4_gnt1");
        chk("t4_fifo_busy", 32'(id_valid), 32'd1);
        tick();
        flush      = 1'b1;
        jmp_target = 32'h1000;
        tick();
        flush = 1'b0;
        neg();
        chk("t4_flushed", 32'(id_valid), 32'd0);
        tick();
        id_ready = 1'b1;
        wait_for(0, 12, "t4_gnt_new");
        chk("t4_addr", imem_addr, 32'h1000);
        tick();
        wait_for(2, 12, "t4_valid");
        chk("t4_pc", id_pc, 32'h1000);
        chk("t4_inst", id_inst, 32'h1000_EFFF);

        // Flush coinciding with the returning word.
        tick();
        lat = 2;
        wait_for(0, 12, "t5_gnt");
        tick();
        tick();
        flush      = 1'b1;
        jmp_target = 32'h2000;
        tick();
        flush = 1'b0;
        neg();
        chk("t5_req_drop", 32'(imem_req), 32'd0);
        tick();
        wait_for(0, 12, "t5_gnt_new");
        chk("t5_addr", imem_addr, 32'h2000);

        // Flush during an ungranted request.
        tick();
        gnt_en = 1'b0;
        wait_for(1, 12, "t5b_req");
        tick();
        flush      = 1'b1;
        jmp_target = 32'h3000;
        tick();
        flush = 1'b0;
        neg();
        chk("t5b_req_drop", 32'(imem_req), 32'd0);
        tick();
        gnt_en = 1'b1;
        wait_for(0, 12, "t5b_gnt");
        chk("t5b_addr", imem_addr, 32'h3000);

        // Reset while waiting; stray read data during and after reset.
        tick();
        lat = 4;
        wait_for(0, 12, "t6_gnt");
        tick();
        rst = 1'b0;
        tick();
        inj_rv = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        tick();
        inj_rv = 1'b0;
        wait_for(2, 20, "t6_valid");
        chk("t6_pc", id_pc, 32'd0);
        chk("t6_inst", id_inst, 32'h0000_FFFF);

        repeat (6) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
